// File: rtl/femto_uart_pkg.sv
// Shared UART definitions: transmitter FSM states and line levels.
// Kept generic so a future receiver can import the same package.
package femto_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// Bit-period down-counter: load with period at each bit boundary, tick marks
// the last cycle of the period, so one bit lasts period+1 cycles.
module baud_tick #(
    parameter int DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load,
    input  logic [DIV_BITS-1:0] period,
    output logic                tick
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = period;
        else if (cnt_q != '0)
            cnt_d = cnt_q - DIV_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a FWFT fifo: pops a byte, sends start/data/parity/stop,
// and chains frames with no idle gap while the fifo holds data.
module uart_tx_fifo_drain
    import femto_uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DIV_BITS-1:0]  div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    input  logic [DATA_BITS-1:0] fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_r,
    output logic                 tx,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);

    uart_tx_state_e       state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]       bitcnt_q, bitcnt_d;
    logic [DIV_BITS-1:0]  div_q, div_d;
    logic                 par_q, par_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tick, pop, stop_done, baud_load;
    logic [DIV_BITS-1:0]  baud_period;

    // Pop on the final cycle of the final stop bit so the next start bit follows directly.
    assign stop_done   = (state_q == STOP) && tick && (!stop2_q || bitcnt_q == BCW'(1));
    assign pop         = rstn && !fifo_empty && ((state_q == IDLE) || stop_done);
    assign baud_load   = pop || (tick && (state_q != IDLE));
    assign baud_period = pop ? div : div_q;

    baud_tick #(.DIV_BITS(DIV_BITS)) u_baud (
        .clk    (clk),
        .rstn   (rstn),
        .load   (baud_load),
        .period (baud_period),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        div_d     = div_q;
        par_d     = par_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        if (pop) begin
            state_d   = START;
            shreg_d   = fifo_dout;
            bitcnt_d  = '0;
            div_d     = div;
            par_d     = 1'b0;
            par_en_d  = parity_en;
            par_odd_d = parity_odd;
            stop2_d   = stop2;
            tx_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: tx_d = UART_IDLE_LEVEL;
                START: if (tick) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                    tx_d     = shreg_q[0];
                end
                DATA: if (tick) begin
                    par_d    = par_q ^ shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + BCW'(1);
                    tx_d     = shreg_d[0];
                    if (bitcnt_q == LAST_DATA) begin
                        bitcnt_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_d ^ par_odd_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = UART_IDLE_LEVEL;
                        end
                    end
                end
                PARITY: if (tick) begin
                    state_d  = STOP;
                    bitcnt_d = '0;
                    tx_d     = UART_IDLE_LEVEL;
                end
                STOP: if (tick) begin
                    if (stop_done)
                        state_d = IDLE;
                    else
                        bitcnt_d = bitcnt_q + BCW'(1);
                    tx_d = UART_IDLE_LEVEL;
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = UART_IDLE_LEVEL;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            div_q     <= '0;
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= UART_IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            div_q     <= div_d;
            par_q     <= par_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign fifo_r = pop;
    assign tx     = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench: a queue-backed FWFT fifo feeds the transmitter; tx/busy/fifo_r are
// logged every cycle and compared against hand-built expected frame waveforms.
module tb_uart_tx_fifo_drain;

    localparam int LOGN = 4096;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] div;
    logic        parity_en, parity_odd, stop2;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_r, tx, busy;

    logic [7:0]  q[$];
    logic        tx_s   [0:LOGN-1];
    logic        busy_s [0:LOGN-1];
    logic        pop_s  [0:LOGN-1];
    int          log_n = 0;
    int          n_chk = 0;
    int          n_err = 0;

    uart_tx_fifo_drain #(.DATA_BITS(8), .DIV_BITS(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .div        (div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_r     (fifo_r),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (q.size() == 0);
        fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_sync();
    endtask

    // Called at a negedge; advances n cycles, popping the model fifo and logging outputs.
    task automatic step(input int n);
        logic pend;
        for (int i = 0; i < n; i++) begin
            #1 pend = fifo_r;
            @(posedge clk);
            #1;
            if (pend && q.size() != 0) void'(q.pop_front());
            fifo_sync();
            @(negedge clk);
            if (log_n < LOGN) begin
                tx_s[log_n]   = tx;
                busy_s[log_n] = busy;
                pop_s[log_n]  = fifo_r;
                log_n++;
            end
        end
    endtask

    function automatic logic [255:0] pack(input int sel, input int base);
        logic [255:0] v;
        for (int i = 0; i < 256; i++) begin
            if (base + i < LOGN)
                v[i] = (sel == 0) ? tx_s[base+i] : (sel == 1) ? busy_s[base+i] : pop_s[base+i];
            else
                v[i] = 1'bx;
        end
        return v;
    endfunction

    task automatic add_frame(inout logic [255:0] tv, inout logic [255:0] bv, input int off,
                             input logic [7:0] d, input int dv, input bit pen,
                             input bit podd, input bit s2);
        int   p, nb;
        logic val;
        p  = dv + 1;
        nb = 10 + int'(pen) + int'(s2);
        for (int b = 0; b < nb; b++) begin
            if (b == 0)              val = 1'b0;
            else if (b <= 8)         val = d[b-1];
            else if (pen && b == 9)  val = (^d) ^ podd;
            else                     val = 1'b1;
            for (int c = 0; c < p; c++) begin
                tv[off + b*p + c] = val;
                bv[off + b*p + c] = 1'b1;
            end
        end
    endtask

    initial begin
        logic [255:0] etx, ebusy, epop;
        int           base;
        logic         all_tx, any_r, any_busy;

        rstn = 1'b0; div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        fifo_sync();
        @(negedge clk);
        step(3);
        chk("reset_tx",     tx_s[log_n-1],   1'b1);
        chk("reset_busy",   busy_s[log_n-1], 1'b0);
        chk("reset_fifo_r", pop_s[log_n-1],  1'b0);
        rstn = 1'b1;
        step(2);

        // single frame 0x55, div=3, no parity, 1 stop
        push(8'h55);
        base = log_n;
        #1 chk("single_pop_now", fifo_r, 1'b1);
        step(256);
        etx = '1; ebusy = '0; epop = '0;
        add_frame(etx, ebusy, 0, 8'h55, 3, 0, 0, 0);
        chk("single_tx",   pack(0, base), etx);
        chk("single_busy", pack(1, base), ebusy);
        chk("single_pops", pack(2, base), epop);

        // parity 0x07, div=1, even then odd
        for (int k = 0; k < 2; k++) begin
            div = 16'd1; parity_en = 1'b1; parity_odd = k[0]; stop2 = 1'b0;
            push(8'h07);
            base = log_n;
            step(256);
            etx = '1; ebusy = '0;
            add_frame(etx, ebusy, 0, 8'h07, 1, 1, k[0], 0);
            chk(k == 0 ? "par_even_tx" : "par_odd_tx", pack(0, base), etx);
            chk(k == 0 ? "par_even_busy" : "par_odd_busy", pack(1, base), ebusy);
            chk(k == 0 ? "par_even_bit" : "par_odd_bit", tx_s[base+18], (k == 0) ? 1'b1 : 1'b0);
        end

        // back-to-back 0xA5, 0x3C, div=0, parity even, 2 stop bits: 12-cycle frames
        div = 16'd0; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
        push(8'hA5); push(8'h3C);
        base = log_n;
        step(256);
        etx = '1; ebusy = '0; epop = '0;
        add_frame(etx, ebusy, 0,  8'hA5, 0, 1, 0, 1);
        add_frame(etx, ebusy, 12, 8'h3C, 0, 1, 0, 1);
        epop[11] = 1'b1;
        chk("b2b_tx",   pack(0, base), etx);
        chk("b2b_busy", pack(1, base), ebusy);
        chk("b2b_pops", pack(2, base), epop);

        // div changes 3 -> 7 during the data bits of frame 1
        div = 16'd3; parity_en = 1'b0; stop2 = 1'b0;
        push(8'hC3); push(8'h5A);
        base = log_n;
        step(10);
        div = 16'd7;
        step(246);
        etx = '1; ebusy = '0; epop = '0;
        add_frame(etx, ebusy, 0,  8'hC3, 3, 0, 0, 0);
        add_frame(etx, ebusy, 40, 8'h5A, 7, 0, 0, 0);
        epop[39] = 1'b1;
        chk("middiv_tx",   pack(0, base), etx);
        chk("middiv_busy", pack(1, base), ebusy);
        chk("middiv_pops", pack(2, base), epop);

        // reset during the 3rd data bit with another byte queued
        div = 16'd3;
        push(8'h55); push(8'h81);
        step(13);
        rstn = 1'b0;
        step(1);
        chk("rst_mid_tx",     tx_s[log_n-1],   1'b1);
        chk("rst_mid_busy",   busy_s[log_n-1], 1'b0);
        chk("rst_mid_fifo_r", pop_s[log_n-1],  1'b0);
        step(1);
        chk("rst_hold_fifo_r", pop_s[log_n-1], 1'b0);
        rstn = 1'b1;
        base = log_n;
        #1 chk("rst_after_pop", fifo_r, 1'b1);
        step(256);
        etx = '1; ebusy = '0;
        add_frame(etx, ebusy, 0, 8'h81, 3, 0, 0, 0);
        chk("rst_after_tx",   pack(0, base), etx);
        chk("rst_after_busy", pack(1, base), ebusy);

        // empty fifo for 100 cycles
        base = log_n;
        step(100);
        all_tx = 1'b1; any_r = 1'b0; any_busy = 1'b0;
        for (int i = base; i < base + 100; i++) begin
            all_tx   &= tx_s[i];
            any_r    |= pop_s[i];
            any_busy |= busy_s[i];
        end
        chk("empty_tx",     all_tx,   1'b1);
        chk("empty_fifo_r", any_r,    1'b0);
        chk("empty_busy",   any_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
